// File: rtl/des_key_scheduler_if.sv
// Round-key stream from the DES key scheduler to the round engine.
// The scheduler drives the key fields; the consumer drives rk_ready.
interface des_key_scheduler_if #(
  parameter int IDX_W = 2
);
  logic             rk_valid;
  logic             rk_ready;
  logic [47:0]      rk_data;
  logic [3:0]       rk_round;
  logic [IDX_W-1:0] rk_key_idx;
  logic             rk_last;

  modport master (
    output rk_valid, rk_data, rk_round, rk_key_idx, rk_last,
    input  rk_ready
  );

  modport slave (
    input  rk_valid, rk_data, rk_round, rk_key_idx, rk_last,
    output rk_ready
  );
endinterface

// File: rtl/des_key_scheduler.sv
// Streaming DES round-key scheduler: NUM_KEYS user keys, 16 round keys each,
// encrypt (K1..K16) or decrypt (K16..K1) order selected per key.
module des_key_scheduler #(
  parameter int NUM_KEYS = 3,
  parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic [64*NUM_KEYS-1:0]   user_keys,
  input  logic [NUM_KEYS-1:0]      key_mode,
  output logic                     busy,
  output logic                     done,
  des_key_scheduler_if.master      rk
);

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit n set where the DES shift schedule s[n] is 2 rather than 1.
  localparam logic [16:1] SHIFT2 = 16'b0111_1110_1111_1100;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] res;
    res = '0;
    for (int j = 0; j < 56; j++) res[55-j] = k[64-PC1[j]];
    return res;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] res;
    res = '0;
    for (int j = 0; j < 48; j++) res[47-j] = cd[56-PC2[j]];
    return res;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic left,
                                        input logic two);
    logic [27:0] res;
    case ({left, two})
      2'b10:   res = {x[26:0], x[27]};
      2'b11:   res = {x[25:0], x[27:26]};
      2'b00:   res = {x[0], x[27:1]};
      default: res = {x[1:0], x[27:2]};
    endcase
    return res;
  endfunction

  state_t                    state;
  logic [NUM_KEYS-1:0][55:0] keys_q;
  logic [NUM_KEYS-1:0]       mode_q;
  logic [IDX_W-1:0]          key_idx;
  logic [3:0]                round;
  logic [55:0]               cd;

  // Only the 56 PC-1 bits of each key are kept; parity never enters the state.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        keys_q[g] <= '0;
        mode_q[g] <= 1'b0;
      end else if (state == IDLE && start) begin
        keys_q[g] <= pc1(user_keys[64*g +: 64]);
        mode_q[g] <= key_mode[g];
      end
    end
  end

  logic [55:0] load_cd;
  logic        cur_enc;
  logic        cur_two;
  logic        last_key;
  logic [4:0]  enc_sidx;
  logic [4:0]  dec_sidx;

  always_comb begin
    load_cd  = keys_q[key_idx];
    cur_enc  = mode_q[key_idx];
    last_key = (key_idx == IDX_W'(NUM_KEYS - 1));
    enc_sidx = {1'b0, round} + 5'd2;
    dec_sidx = 5'd16 - {1'b0, round};
    cur_two  = cur_enc ? SHIFT2[enc_sidx] : SHIFT2[dec_sidx];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      key_idx <= '0;
      round   <= '0;
      cd      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_idx <= '0;
            round   <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          // C0D0 doubles as C16D16, so decrypt starts straight from PC-1.
          cd    <= cur_enc ? {rot28(load_cd[55:28], 1'b1, 1'b0),
                              rot28(load_cd[27:0],  1'b1, 1'b0)}
                           : load_cd;
          round <= '0;
          state <= STREAM;
        end
        STREAM: begin
          if (rk.rk_ready) begin
            if (round != 4'd15) begin
              round <= round + 4'd1;
              cd    <= {rot28(cd[55:28], cur_enc, cur_two),
                        rot28(cd[27:0],  cur_enc, cur_two)};
            end else if (last_key) begin
              done    <= 1'b1;
              key_idx <= '0;
              round   <= '0;
              state   <= IDLE;
            end else begin
              key_idx <= key_idx + IDX_W'(1);
              round   <= '0;
              state   <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy          = (state != IDLE);
    rk.rk_valid   = (state == STREAM);
    rk.rk_data    = (state == STREAM) ? pc2(cd) : '0;
    rk.rk_round   = round;
    rk.rk_key_idx = key_idx;
    rk.rk_last    = (state == STREAM) && (round == 4'd15) && last_key;
  end

endmodule

// File: tb/tb_des_key_scheduler.sv
// Randomised bench for des_key_scheduler against a closed-form DES key model.
module tb_des_key_scheduler;
  localparam int N  = 3;
  localparam int IW = 2;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [47:0] KV [16] = '{
    48'he0be66ce0b2b, 48'he0b67635c5a2, 48'he4d676cc0c47, 48'he6d372cee2dc,
    48'haed37331d7c9, 48'haf535b9a9423, 48'h2f53d9ce6f24, 48'h1f59d9386bd8,
    48'h1f49d9c62c75, 48'h1f699dab8bdc, 48'h1f2d8d11d793, 48'h5b2cad5f0425,
    48'hd9acacca69cc, 48'hd0aeae20f39d, 48'hf0be26f314a3, 48'hf0be262bf356
  };
  localparam logic [63:0] KEYV = 64'h736865726c6f636b;

  typedef struct packed {
    logic [47:0]   d;
    logic [3:0]    r;
    logic [IW-1:0] k;
    logic          l;
  } exp_t;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             start = 1'b0;
  logic [64*N-1:0]  user_keys = '0;
  logic [N-1:0]     key_mode = '0;
  logic             busy, done;

  des_key_scheduler_if #(.IDX_W(IW)) rk_bus ();

  des_key_scheduler #(.NUM_KEYS(N), .IDX_W(IW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .user_keys(user_keys),
    .key_mode(key_mode), .busy(busy), .done(done), .rk(rk_bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Ki computed directly: rotate C0/D0 by the cumulative shift, then PC-2.
  function automatic logic [47:0] ref_rk(input logic [63:0] key, input int i);
    bit c0 [56];
    bit cd [56];
    int sh;
    logic [47:0] res;
    for (int j = 0; j < 56; j++) c0[j] = key[64-PC1[j]];
    sh = 0;
    for (int n = 0; n < i; n++) sh += SH[n];
    for (int j = 0; j < 28; j++) begin
      cd[j]    = c0[(j + sh) % 28];
      cd[28+j] = c0[28 + (j + sh) % 28];
    end
    res = '0;
    for (int j = 0; j < 48; j++) res[47-j] = cd[PC2[j]-1];
    return res;
  endfunction

  task automatic run(input logic [64*N-1:0] keys, input logic [N-1:0] mode,
                     input int pct, input bit use_kv, input bit poke);
    exp_t q[$];
    exp_t e;
    int cyc, hs, bub, idx;
    bit got_done, prev_stall, poked;
    logic [47:0] pd;
    logic [3:0] pr;
    logic [IW-1:0] pk;
    logic pl;
    for (int k = 0; k < N; k++)
      for (int r = 0; r < 16; r++) begin
        idx = mode[k] ? r + 1 : 16 - r;
        e.d = use_kv ? KV[idx-1] : ref_rk(keys[64*k +: 64], idx);
        e.r = 4'(r);
        e.k = IW'(k);
        e.l = (k == N - 1) && (r == 15);
        q.push_back(e);
      end
    @(posedge clk); #1;
    start = 1'b1; user_keys = keys; key_mode = mode; rk_bus.rk_ready = 1'b0;
    @(negedge clk);
    chk("busy_pre", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    user_keys = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key_mode = ~mode;
    cyc = 0; hs = 0; bub = 0; got_done = 0; prev_stall = 0; poked = 0;
    pd = '0; pr = '0; pk = '0; pl = 1'b0;
    while (!got_done && cyc < 3000) begin
      rk_bus.rk_ready = ($urandom_range(99) < pct);
      start = 1'b0;
      if (poke && hs >= 20 && !poked) begin
        start = 1'b1; poked = 1;
      end
      @(negedge clk);
      if (cyc == 0) chk("busy_rise", busy, 1);
      if (done) begin
        got_done = 1;
        chk("done_empty", q.size(), 0);
        chk("done_busy", busy, 0);
        chk("done_valid", rk_bus.rk_valid, 0);
        if (pct >= 100) chk("done_lat", cyc, 17 * N);
      end else begin
        if (prev_stall) begin
          chk("stall_valid", rk_bus.rk_valid, 1);
          chk("stall_data", rk_bus.rk_data, pd);
          chk("stall_round", rk_bus.rk_round, pr);
          chk("stall_idx", rk_bus.rk_key_idx, pk);
          chk("stall_last", rk_bus.rk_last, pl);
        end
        if (rk_bus.rk_valid) begin
          if (rk_bus.rk_ready) begin
            if (q.size() == 0) begin
              chk("extra_hs", 1, 0);
            end else begin
              e = q.pop_front();
              chk("rk_data", rk_bus.rk_data, e.d);
              chk("rk_round", rk_bus.rk_round, e.r);
              chk("rk_key_idx", rk_bus.rk_key_idx, e.k);
              chk("rk_last", rk_bus.rk_last, e.l);
            end
            hs++;
          end
        end else begin
          if (busy) bub++;
          chk("idle_data", rk_bus.rk_data, 0);
          chk("idle_last", rk_bus.rk_last, 0);
        end
        prev_stall = rk_bus.rk_valid && !rk_bus.rk_ready;
        pd = rk_bus.rk_data; pr = rk_bus.rk_round;
        pk = rk_bus.rk_key_idx; pl = rk_bus.rk_last;
      end
      @(posedge clk); cyc++; #1;
    end
    start = 1'b0;
    rk_bus.rk_ready = 1'b0;
    chk("got_done", got_done, 1);
    chk("hs_count", hs, 16 * N);
    chk("bubbles", bub, N);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  task automatic check_all_low(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, rk_bus.rk_valid, 0);
    chk({tag, "_data"}, rk_bus.rk_data, 0);
    chk({tag, "_round"}, rk_bus.rk_round, 0);
    chk({tag, "_idx"}, rk_bus.rk_key_idx, 0);
    chk({tag, "_last"}, rk_bus.rk_last, 0);
  endtask

  task automatic reset_mid;
    bit hit;
    @(posedge clk); #1;
    start = 1'b1; user_keys = {N{KEYV}}; key_mode = '1; rk_bus.rk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      hit = rk_bus.rk_valid && rk_bus.rk_round == 4'd7;
    end
    chk("reach_r7", hit, 1);
    #2 n_rst = 1'b0;
    #1 check_all_low("arst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("arst_done", done, 0);
      chk("arst_busy", busy, 0);
    end
    n_rst = 1'b1;
    rk_bus.rk_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy, 0);
  endtask

  initial begin
    logic [64*N-1:0] rk;
    rk_bus.rk_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_low("rst");
    n_rst = 1'b1;

    run({N{KEYV}}, 3'b111, 100, 1, 0);
    run({N{KEYV}}, 3'b000, 100, 1, 0);
    run({N{KEYV}}, 3'b101, 100, 1, 0);
    run({N{KEYV}} ^ {(8*N){8'h01}}, 3'($urandom), 100, 1, 0);
    run({N{KEYV}}, 3'b101, 50, 1, 1);
    repeat (4) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run(rk, 3'($urandom), $urandom_range(100, 30), 0, 0);
    end
    reset_mid();
    run({N{KEYV}}, 3'b111, 100, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
